// File: rtl/lm32_trace_ctrl_pkg.sv
// Shared encodings for the LM32 retired-instruction trace controller.
package lm32_trace_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic capture_state(input logic [1:0] st);
        return (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/lm32_trace_ctrl_ram.sv
// Trace buffer storage: one write port, synchronous read port whose output
// register returns to zero whenever no read is issued.
module lm32_trace_ctrl_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 62
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Array write, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register with one-cycle latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/lm32_trace_ctrl.sv
// Retired-instruction trace controller: follows D-stage instructions to W,
// captures committed {pc, instruction} pairs and replays the frozen history.
module lm32_trace_ctrl
    import lm32_trace_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int PC_WIDTH   = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     stall_x,
    input  logic                     stall_m,
    input  logic                     valid_w,
    input  logic                     kill_w,
    input  logic [31:0]              instruction_d,
    input  logic [PC_WIDTH-1:0]      pc_w,
    input  logic                     arm_i,
    input  logic                     stop_i,
    input  logic                     trig_en_i,
    input  logic [PC_WIDTH-1:0]      trig_pc_i,
    input  logic [DEPTH_LOG2:0]      post_count_i,
    input  logic                     rd_req_i,
    output logic                     rd_ack_o,
    output logic [PC_WIDTH+31:0]     rd_data_o,
    output logic                     rd_last_o,
    output logic [1:0]               state_o,
    output logic [DEPTH_LOG2:0]      count_o
);

    localparam int                    ENTRY_W = PC_WIDTH + 32;
    localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = {DEPTH_LOG2{1'b1}};

    logic [31:0]           instruction_x_r, instruction_m_r, instruction_w_r;
    logic [1:0]            state_r;
    logic [DEPTH_LOG2-1:0] wptr_r;
    logic                  wrapped_r;
    logic [DEPTH_LOG2:0]   count_r, remaining_r, rd_idx_r;
    logic                  rd_ack_r, rd_last_r;

    logic                  retire_s, write_s, match_s, rd_issue_s;
    logic [DEPTH_LOG2-1:0] oldest_s, rd_addr_s;
    logic [DEPTH_LOG2:0]   rd_idx_next_s;

    // Retire qualification, trigger compare and read-pointer arithmetic.
    always_comb begin
        retire_s      = valid_w && !kill_w;
        write_s       = retire_s && capture_state(state_r) && !arm_i;
        match_s       = trig_en_i && (pc_w == trig_pc_i);
        oldest_s      = wrapped_r ? wptr_r : '0;
        rd_addr_s     = oldest_s + rd_idx_r[DEPTH_LOG2-1:0];
        rd_idx_next_s = rd_idx_r + CNT_ONE;
        rd_issue_s    = (state_r == ST_DONE) && rd_req_i && (rd_idx_r < count_r) && !arm_i;
    end

    // Instruction shadow of the X/M/W pipeline registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instruction_x_r <= '0;
            instruction_m_r <= '0;
            instruction_w_r <= '0;
        end else begin
            if (!stall_x) begin
                instruction_x_r <= instruction_d;
            end
            if (!stall_m) begin
                instruction_m_r <= instruction_x_r;
            end
            instruction_w_r <= instruction_m_r;
        end
    end

    // Capture pointers, arm/trigger/post state machine and readout progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_IDLE;
            wptr_r      <= '0;
            wrapped_r   <= 1'b0;
            count_r     <= '0;
            remaining_r <= '0;
            rd_idx_r    <= '0;
        end else if (arm_i) begin
            state_r     <= ST_ARMED;
            wptr_r      <= '0;
            wrapped_r   <= 1'b0;
            count_r     <= '0;
            remaining_r <= '0;
            rd_idx_r    <= '0;
        end else begin
            if (write_s) begin
                wptr_r  <= wptr_r + PTR_ONE;
                count_r <= (wrapped_r || (wptr_r == PTR_MAX)) ? FULL : {1'b0, wptr_r + PTR_ONE};
                if (wptr_r == PTR_MAX) begin
                    wrapped_r <= 1'b1;
                end
            end
            if (rd_issue_s) begin
                rd_idx_r <= rd_idx_next_s;
            end
            case (state_r)
                ST_ARMED: begin
                    // A stop freezes capture even when the same retire matches.
                    if (stop_i) begin
                        state_r <= ST_DONE;
                    end else if (write_s && match_s) begin
                        if (post_count_i == '0) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r     <= ST_POST;
                            remaining_r <= post_count_i;
                        end
                    end
                end
                ST_POST: begin
                    if (stop_i) begin
                        state_r <= ST_DONE;
                    end else if (write_s) begin
                        remaining_r <= remaining_r - CNT_ONE;
                        if (remaining_r == CNT_ONE) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_ack_r && rd_last_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read handshake flags aligned with the RAM read latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ack_r  <= 1'b0;
            rd_last_r <= 1'b0;
        end else begin
            rd_ack_r  <= rd_issue_s;
            rd_last_r <= rd_issue_s && (rd_idx_next_s == count_r);
        end
    end

    lm32_trace_ctrl_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .wr_en   (write_s),
        .wr_addr (wptr_r),
        .wr_data ({pc_w, instruction_w_r}),
        .rd_en   (rd_issue_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_o)
    );

    assign rd_ack_o  = rd_ack_r;
    assign rd_last_o = rd_last_r;
    assign state_o   = state_r;
    assign count_o   = count_r;

endmodule

// File: tb/tb_lm32_trace_ctrl.sv
// Bench for lm32_trace_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based history model.
module tb_lm32_trace_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_x = 1'b0, stall_m = 1'b0, valid_w = 1'b0, kill_w = 1'b0;
    logic [31:0] instruction_d = 32'd0;
    logic [29:0] pc_w = 30'd0;
    logic        arm = 1'b0, stop = 1'b0, trig_en = 1'b0, rd_req = 1'b0;
    logic [29:0] trig_pc = 30'd0;
    logic [6:0]  post_count = 7'd0;
    logic        rd_ack, rd_last;
    logic [61:0] rd_data;
    logic [1:0]  state;
    logic [6:0]  count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: captured history as a queue, oldest at the front.
    logic [61:0] m_q[$];
    int          m_state, m_left, m_rd;
    logic [31:0] m_x, m_m, m_w;
    bit          m_ack, m_last;
    logic [61:0] m_data;

    always #5 clk = ~clk;

    lm32_trace_ctrl #(.DEPTH_LOG2(6), .PC_WIDTH(30)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_x(stall_x), .stall_m(stall_m),
        .valid_w(valid_w), .kill_w(kill_w), .instruction_d(instruction_d), .pc_w(pc_w),
        .arm_i(arm), .stop_i(stop), .trig_en_i(trig_en), .trig_pc_i(trig_pc),
        .post_count_i(post_count), .rd_req_i(rd_req), .rd_ack_o(rd_ack),
        .rd_data_o(rd_data), .rd_last_o(rd_last), .state_o(state), .count_o(count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_state = 0; m_left = 0; m_rd = 0;
        m_x = 32'd0; m_m = 32'd0; m_w = 32'd0;
        m_ack = 1'b0; m_last = 1'b0; m_data = 62'd0;
    endtask

    task automatic model_step();
        bit          retire, n_ack, n_last;
        logic [61:0] n_data;
        retire = valid_w && !kill_w;
        n_ack = 1'b0; n_last = 1'b0; n_data = 62'd0;
        if (arm) begin
            m_q.delete();
            m_state = 1;
            m_rd = 0;
        end else begin
            if (retire && (m_state == 1 || m_state == 2)) begin
                m_q.push_back({pc_w, m_w});
                if (m_q.size() > 64) void'(m_q.pop_front());
            end
            case (m_state)
                1: if (stop) m_state = 3;
                   else if (retire && trig_en && pc_w == trig_pc) begin
                       if (post_count == 7'd0) m_state = 3;
                       else begin m_state = 2; m_left = int'(post_count); end
                   end
                2: if (stop) m_state = 3;
                   else if (retire) begin
                       m_left--;
                       if (m_left == 0) m_state = 3;
                   end
                3: begin
                    if (m_ack && m_last) m_state = 0;
                    if (rd_req && m_rd < m_q.size()) begin
                        n_ack = 1'b1;
                        n_data = m_q[m_rd];
                        n_last = (m_rd == m_q.size() - 1);
                        m_rd++;
                    end
                end
                default: ;
            endcase
        end
        m_ack = n_ack; m_last = n_last; m_data = n_data;
        m_w = m_m;
        if (!stall_m) m_m = m_x;
        if (!stall_x) m_x = instruction_d;
    endtask

    task automatic compare_all();
        check_eq("state", 64'(state), 64'(m_state));
        check_eq("count", 64'(count), 64'(m_q.size()));
        check_eq("ack", 64'(rd_ack), 64'(m_ack));
        if (m_ack) begin
            check_eq("data", 64'(rd_data), 64'(m_data));
            check_eq("last", 64'(rd_last), 64'(m_last));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_arm();
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic retire_pc(input logic [29:0] pc);
        valid_w = 1'b1; pc_w = pc; instruction_d = $urandom();
        cyc();
        valid_w = 1'b0;
    endtask

    task automatic read_all();
        rd_req = 1'b1;
        for (int i = 0; i < 80 && state != 2'd0; i++) cyc();
        rd_req = 1'b0;
        check_eq("read_to_idle", 64'(state), 64'd0);
    endtask

    initial begin
        int snap;
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ack", 64'(rd_ack), 64'd0);
        check_eq("rst_data", 64'(rd_data), 64'd0);
        check_eq("rst_last", 64'(rd_last), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Pipeline tracking with an X stall and a killed retire.
        do_arm();
        instruction_d = 32'hAAAA0001; cyc();
        stall_x = 1'b1; instruction_d = 32'hBBBB0002; cyc();
        instruction_d = 32'hCCCC0003; cyc();
        stall_x = 1'b0; instruction_d = 32'hDDDD0004; cyc();
        for (int i = 0; i < 5; i++) retire_pc(30'h10 + 30'(i));
        snap = m_q.size();
        valid_w = 1'b1; kill_w = 1'b1; pc_w = 30'h77; cyc();
        valid_w = 1'b0; kill_w = 1'b0;
        check_eq("kill_count", 64'(count), 64'(snap));
        stop = 1'b1; cyc(); stop = 1'b0;
        read_all();

        // Trigger at 0x100 with three post entries.
        trig_en = 1'b1; trig_pc = 30'h100; post_count = 7'd3;
        do_arm();
        retire_pc(30'hFC); retire_pc(30'h100); retire_pc(30'h101);
        retire_pc(30'h102); retire_pc(30'h103); retire_pc(30'h104);
        check_eq("trig_state", 64'(state), 64'd3);
        check_eq("trig_count", 64'(count), 64'd5);
        read_all();

        // Wrap-around: 70 retires without a trigger.
        trig_en = 1'b0;
        do_arm();
        for (int i = 0; i < 70; i++) retire_pc(30'(i));
        stop = 1'b1; cyc(); stop = 1'b0;
        check_eq("wrap_count", 64'(count), 64'd64);
        rd_req = 1'b1; cyc();
        check_eq("wrap_first_pc", 64'(rd_data[61:32]), 64'd6);
        read_all();

        // Zero post count finishes on the trigger entry itself.
        trig_en = 1'b1; trig_pc = 30'h20; post_count = 7'd0;
        do_arm();
        retire_pc(30'h1E); retire_pc(30'h1F); retire_pc(30'h20);
        check_eq("post0_state", 64'(state), 64'd3);
        read_all();

        // Arm and stop together, then arm in the middle of a readout.
        trig_en = 1'b0;
        do_arm();
        retire_pc(30'h5); retire_pc(30'h6);
        arm = 1'b1; stop = 1'b1; cyc(); arm = 1'b0; stop = 1'b0;
        check_eq("armstop_state", 64'(state), 64'd1);
        check_eq("armstop_count", 64'(count), 64'd0);
        for (int i = 0; i < 6; i++) retire_pc(30'h30 + 30'(i));
        stop = 1'b1; cyc(); stop = 1'b0;
        rd_req = 1'b1; cyc(); cyc();
        arm = 1'b1; cyc(); arm = 1'b0;
        cyc();
        check_eq("arm_mid_ack", 64'(rd_ack), 64'd0);
        rd_req = 1'b0;

        // Asynchronous reset while in POST.
        trig_en = 1'b1; trig_pc = 30'h40; post_count = 7'd5;
        retire_pc(30'h40); retire_pc(30'h41);
        check_eq("pre_rst_post", 64'(state), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", 64'(state), 64'd0);
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_ack", 64'(rd_ack), 64'd0);
        check_eq("arst_data", 64'(rd_data), 64'd0);
        m_reset();
        rd_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();
        check_eq("arst_no_ack", 64'(rd_ack), 64'd0);
        rd_req = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            stall_x = ($urandom_range(0, 4) == 0);
            stall_m = ($urandom_range(0, 5) == 0);
            valid_w = ($urandom_range(0, 9) < 7);
            kill_w = ($urandom_range(0, 4) == 0);
            instruction_d = $urandom();
            pc_w = 30'($urandom_range(0, 15));
            arm = ($urandom_range(0, 99) == 0);
            stop = ($urandom_range(0, 149) == 0);
            rd_req = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 49) == 0) begin
                trig_en = ($urandom_range(0, 3) != 0);
                trig_pc = 30'($urandom_range(0, 15));
                post_count = 7'($urandom_range(0, 70));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
